// File: rtl/dram_controller_if.sv
// 68000-side bus bundle for the FPM DRAM controller: CPU strobes/address in,
// multiplexed DRAM address, strobes and DTACK out.
interface dram_controller_if;
   logic        AS;
   logic        UDS;
   logic        LDS;
   logic        RW;
   logic        DRAM_SEL;
   logic [22:1] ADDR;
   logic [10:0] MA;
   logic        RAS;
   logic        CASU;
   logic        CASL;
   logic        WE;
   logic        DTACK;
   logic        REF_BUSY;

   modport master (
      output AS, UDS, LDS, RW, DRAM_SEL, ADDR,
      input  MA, RAS, CASU, CASL, WE, DTACK, REF_BUSY
   );

   modport slave (
      input  AS, UDS, LDS, RW, DRAM_SEL, ADDR,
      output MA, RAS, CASU, CASL, WE, DTACK, REF_BUSY
   );
endinterface

// File: rtl/dram_controller.sv
// FPM DRAM sequencer: turns 68000 bus cycles into RAS/CAS accesses with DTACK,
// interleaved with periodic CAS-before-RAS refresh.
module dram_controller #(
   parameter int unsigned REFRESH_PERIOD = 240,
   parameter int unsigned RAS_HOLD       = 3,
   parameter int unsigned T_RP           = 2
) (
   input logic               CLK,
   input logic               RST,
   dram_controller_if.slave  bus
);

   localparam int unsigned CW   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam int unsigned TMAX = (RAS_HOLD > T_RP) ? RAS_HOLD : T_RP;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_PERIOD - 1);
   localparam logic [TW-1:0] RAS_LOAD = TW'(RAS_HOLD - 1);
   localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);

   typedef enum logic [2:0] {
      IDLE, ACC_RAS, ACC_COL, ACC_CAS, REF_CAS, REF_RAS, PRECHARGE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ref_cnt_q, ref_cnt_d;
   logic [1:0]      pend_q, pend_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            ras_q, ras_d;
   logic            casu_q, casu_d;
   logic            casl_q, casl_d;
   logic            we_q, we_d;
   logic            dtack_q, dtack_d;
   logic            ref_busy_q, ref_busy_d;
   logic            req, wrap, ref_done;

   assign req  = ~bus.AS & ~bus.DRAM_SEL & (~bus.UDS | ~bus.LDS);
   assign wrap = (ref_cnt_q == CNT_LAST);

   always_comb begin
      ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
      // wrap and completion together cancel, so the count is unchanged
      if (wrap && !ref_done && pend_q != 2'd3)
         pend_d = pend_q + 2'd1;
      else if (ref_done && !wrap)
         pend_d = pend_q - 2'd1;
      else
         pend_d = pend_q;
   end

   // Strobes are registered from the current state, so pins lag state by one cycle.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      ras_d      = 1'b1;
      casu_d     = 1'b1;
      casl_d     = 1'b1;
      we_d       = 1'b1;
      dtack_d    = 1'b1;
      ref_busy_d = 1'b0;
      ref_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q != 2'd0) state_d = REF_CAS;
            else if (req)       state_d = ACC_RAS;
         end
         ACC_RAS, ACC_COL, ACC_CAS: begin
            if (bus.AS) begin
               state_d = PRECHARGE;
               tmr_d   = RP_LOAD;
            end else begin
               ras_d = 1'b0;
               we_d  = (state_q == ACC_RAS) ? bus.RW : we_q;
               if (state_q == ACC_RAS) state_d = ACC_COL;
               if (state_q == ACC_COL) state_d = ACC_CAS;
               if (state_q == ACC_CAS) begin
                  casu_d  = bus.UDS;
                  casl_d  = bus.LDS;
                  dtack_d = bus.DRAM_SEL;
               end
            end
         end
         REF_CAS: begin
            casu_d     = 1'b0;
            casl_d     = 1'b0;
            ref_busy_d = 1'b1;
            tmr_d      = RAS_LOAD;
            state_d    = REF_RAS;
         end
         REF_RAS: begin
            ras_d      = 1'b0;
            casu_d     = 1'b0;
            casl_d     = 1'b0;
            ref_busy_d = 1'b1;
            if (tmr_q == '0) begin
               state_d  = PRECHARGE;
               tmr_d    = RP_LOAD;
               ref_done = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         PRECHARGE: begin
            if (tmr_q == '0) state_d = IDLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         ref_cnt_q  <= '0;
         pend_q     <= '0;
         tmr_q      <= '0;
         ras_q      <= 1'b1;
         casu_q     <= 1'b1;
         casl_q     <= 1'b1;
         we_q       <= 1'b1;
         dtack_q    <= 1'b1;
         ref_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_cnt_q  <= ref_cnt_d;
         pend_q     <= pend_d;
         tmr_q      <= tmr_d;
         ras_q      <= ras_d;
         casu_q     <= casu_d;
         casl_q     <= casl_d;
         we_q       <= we_d;
         dtack_q    <= dtack_d;
         ref_busy_q <= ref_busy_d;
      end
   end

   assign bus.MA       = (state_q == ACC_COL || state_q == ACC_CAS) ? bus.ADDR[11:1]
                                                                    : bus.ADDR[22:12];
   assign bus.RAS      = ras_q;
   assign bus.CASU     = casu_q;
   assign bus.CASL     = casl_q;
   assign bus.WE       = we_q;
   assign bus.DTACK    = dtack_q;
   assign bus.REF_BUSY = ref_busy_q;

endmodule

// File: tb/tb_dram_controller.sv
// Directed bench for dram_controller: a per-cycle vector table for access
// sequences, then hand-written refresh, collision, saturation and reset cases.
module tb_dram_controller;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   dram_controller_if bus ();

   dram_controller #(
      .REFRESH_PERIOD(240),
      .RAS_HOLD      (3),
      .T_RP          (2)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   // input bits {AS, UDS, LDS, RW, DRAM_SEL}
   localparam logic [4:0] IDL   = 5'b11111;
   localparam logic [4:0] RD_W  = 5'b00010;
   localparam logic [4:0] RD_U  = 5'b00110;
   localparam logic [4:0] WR_L  = 5'b01000;
   localparam logic [4:0] WR_W  = 5'b00000;
   localparam logic [4:0] NOSEL = 5'b00011;
   localparam logic [4:0] NOSTB = 5'b01110;
   // ADDR[22:12] / ADDR[11:1]: A -> row 0x012, col 0x345; B -> row 0x7FF, col 0x000
   localparam logic [22:1] A = 22'h009345;
   localparam logic [22:1] B = 22'h3FF800;

   // expected bits {RAS, CASU, CASL, WE, DTACK, REF_BUSY}
   typedef struct {
      logic [4:0]  inp;
      logic [22:1] addr;
      logic [5:0]  exp;
      logic [10:0] ma;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;
   int   since_rst = 0;

   function automatic vec_t mk(input logic [4:0] inp, input logic [22:1] addr,
                               input logic [5:0] exp, input logic [10:0] ma);
      vec_t v;
      v.inp = inp; v.addr = addr; v.exp = exp; v.ma = ma;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [5:0] exp, input logic [10:0] ma);
      chk({tag, ".RAS"},      bus.RAS,      exp[5]);
      chk({tag, ".CASU"},     bus.CASU,     exp[4]);
      chk({tag, ".CASL"},     bus.CASL,     exp[3]);
      chk({tag, ".WE"},       bus.WE,       exp[2]);
      chk({tag, ".DTACK"},    bus.DTACK,    exp[1]);
      chk({tag, ".REF_BUSY"}, bus.REF_BUSY, exp[0]);
      chk({tag, ".MA"},       bus.MA,       ma);
   endtask

   task automatic drive(input logic [4:0] inp, input logic [22:1] a);
      {bus.AS, bus.UDS, bus.LDS, bus.RW, bus.DRAM_SEL} = inp;
      bus.ADDR = a;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      since_rst++;
   endtask

   task automatic tick_until(input int n);
      while (since_rst < n) tick();
   endtask

   task automatic do_reset();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      since_rst = 0;
   endtask

   initial begin
      int rises;
      int first;
      logic prev;

      drive(IDL, A);
      RST = 1'b0;
      tick();
      do_reset();
      chk_out("reset", 6'b111110, 11'h012);

      // word read
      vecs.push_back(mk(RD_W,  A, 6'b111110, 11'h012));
      vecs.push_back(mk(RD_W,  A, 6'b011110, 11'h345));
      vecs.push_back(mk(RD_W,  A, 6'b011110, 11'h345));
      vecs.push_back(mk(RD_W,  A, 6'b000100, 11'h345));
      vecs.push_back(mk(RD_W,  A, 6'b000100, 11'h345));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      // lower-byte write
      vecs.push_back(mk(WR_L,  B, 6'b111110, 11'h7FF));
      vecs.push_back(mk(WR_L,  B, 6'b011010, 11'h000));
      vecs.push_back(mk(WR_L,  B, 6'b011010, 11'h000));
      vecs.push_back(mk(WR_L,  B, 6'b010000, 11'h000));
      vecs.push_back(mk(WR_L,  B, 6'b010000, 11'h000));
      vecs.push_back(mk(IDL,   B, 6'b111110, 11'h7FF));
      vecs.push_back(mk(IDL,   B, 6'b111110, 11'h7FF));
      vecs.push_back(mk(IDL,   B, 6'b111110, 11'h7FF));
      // abort from ACC_RAS
      vecs.push_back(mk(RD_W,  A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      // abort from ACC_COL (write): WE released, no CAS
      vecs.push_back(mk(WR_W,  A, 6'b111110, 11'h012));
      vecs.push_back(mk(WR_W,  A, 6'b011010, 11'h345));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      // not a request: region not selected / no data strobe
      vecs.push_back(mk(NOSEL, A, 6'b111110, 11'h012));
      vecs.push_back(mk(NOSEL, A, 6'b111110, 11'h012));
      vecs.push_back(mk(NOSTB, A, 6'b111110, 11'h012));
      vecs.push_back(mk(NOSTB, A, 6'b111110, 11'h012));
      // upper-byte read
      vecs.push_back(mk(RD_U,  A, 6'b111110, 11'h012));
      vecs.push_back(mk(RD_U,  A, 6'b011110, 11'h345));
      vecs.push_back(mk(RD_U,  A, 6'b011110, 11'h345));
      vecs.push_back(mk(RD_U,  A, 6'b001100, 11'h345));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));
      vecs.push_back(mk(IDL,   A, 6'b111110, 11'h012));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].inp, vecs[i].addr);
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ma);
      end

      // reset while in ACC_CAS: strobes released with no completion
      drive(RD_W, A);
      repeat (4) tick();
      chk("pre_rst.DTACK", bus.DTACK, 1'b0);
      RST = 1'b0;
      tick();
      chk_out("mid_rst", 6'b111110, 11'h012);
      RST = 1'b1;
      drive(IDL, A);
      since_rst = 0;

      // idle CBR refresh timing and waveform
      tick_until(241);
      chk("ref1_pre.REF_BUSY", bus.REF_BUSY, 1'b0);
      tick();
      chk_out("ref1_c242", 6'b100111, 11'h012);
      tick();
      chk_out("ref1_c243", 6'b000111, 11'h012);
      tick();
      chk("ref1_c244.RAS", bus.RAS, 1'b0);
      tick();
      chk_out("ref1_c245", 6'b000111, 11'h012);
      tick();
      chk_out("ref1_c246", 6'b111110, 11'h012);
      tick_until(481);
      chk("ref2_pre.REF_BUSY", bus.REF_BUSY, 1'b0);
      tick();
      chk("ref2_c482.REF_BUSY", bus.REF_BUSY, 1'b1);

      // write request first seen alongside the pending refresh: refresh wins
      do_reset();
      tick_until(240);
      drive(WR_W, A);
      tick();
      chk("col_c241.REF_BUSY", bus.REF_BUSY, 1'b0);
      for (int c = 242; c <= 248; c++) begin
         tick();
         chk($sformatf("col_c%0d.WE", c),    bus.WE,    1'b1);
         chk($sformatf("col_c%0d.DTACK", c), bus.DTACK, 1'b1);
      end
      chk("col_c248.RAS", bus.RAS, 1'b1);
      tick();
      chk("col_c249.RAS", bus.RAS, 1'b0);
      chk("col_c249.WE",  bus.WE,  1'b0);
      tick();
      chk("col_c250.DTACK", bus.DTACK, 1'b1);
      tick();
      chk_out("col_c251", 6'b000000, 11'h345);
      drive(IDL, A);
      repeat (4) tick();

      // long access: pending saturates at 3, then three back-to-back refreshes
      do_reset();
      drive(RD_W, A);
      tick_until(1000);
      chk("sat_hold.DTACK",    bus.DTACK,    1'b0);
      chk("sat_hold.REF_BUSY", bus.REF_BUSY, 1'b0);
      drive(IDL, A);
      rises = 0;
      first = 0;
      prev  = bus.REF_BUSY;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (bus.REF_BUSY && !prev) begin
            rises++;
            if (rises == 1) first = since_rst;
         end
         prev = bus.REF_BUSY;
      end
      chk("sat_refresh_count", rises, 3);
      chk("sat_first_refresh", first, 1005);
      chk("sat_after.REF_BUSY", bus.REF_BUSY, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
